// File: rtl/decoder_pkg.sv
// Shared encodings and sizes for the sequence decoder: request modes, FSM states,
// and the one-hot helper.
package decoder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CODE_W = 5;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_PULSE = 2'b01,
    MODE_SCAN  = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    HOLD  = 2'b01,
    PULSE = 2'b10,
    SCAN  = 2'b11
  } state_e;

  function automatic logic [DATA_W-1:0] onehot(input logic [CODE_W-1:0] idx);
    return DATA_W'(1) << idx;
  endfunction

endpackage

// File: rtl/pulse_counter.sv
// Down-counter for pulse-mode duration. Load sets PULSE_LEN-1. Terminal count is
// reported both for the current value and for the value after this edge.
module pulse_counter
  import decoder_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc_c,
  output logic tc_next_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(PULSE_LEN - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c      = (cnt_q == '0);
  assign tc_next_c = (cnt_d == '0);

endmodule

// File: rtl/seq_decoder.sv
// 5-to-32 one-hot decoder with hold, timed-pulse and walking-scan request modes.
// All outputs are registered. Reserved mode raises a one-cycle Err.
module seq_decoder
  import decoder_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 1
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic [CODE_W-1:0]   Code,
  input  logic [1:0]          Mode,
  input  logic                Load,
  input  logic                Clear,
  output logic                Ready,
  output logic [DATA_W-1:0]   Data,
  output logic                Done,
  output logic                Err
);

  localparam logic [CODE_W-1:0] CODE_MAX = '1;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CODE_W-1:0]   pos_q, pos_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  mode_e mode_c;
  logic  req_c, accept_c, rsvd_c;
  logic  cnt_tc_c, cnt_tc_next_c;

  assign mode_c   = mode_e'(Mode);
  assign req_c    = Load && ready_q && !Clear;
  assign accept_c = req_c && (mode_c != MODE_RSVD);
  assign rsvd_c   = req_c && (mode_c == MODE_RSVD);

  pulse_counter #(
    .PULSE_LEN (PULSE_LEN)
  ) u_pulse_counter (
    .clk       (Clock),
    .rst_n     (Resetn),
    .load      (accept_c && (mode_c == MODE_PULSE)),
    .en        (state_q == PULSE),
    .tc_c      (cnt_tc_c),
    .tc_next_c (cnt_tc_next_c)
  );

  // Done is registered, so it is raised on the edge that enters the final cycle.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pos_d   = pos_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (Clear) begin
      state_d = IDLE;
      data_d  = '0;
    end else if (accept_c) begin
      data_d = onehot(Code);
      pos_d  = Code;
      case (mode_c)
        MODE_HOLD:  state_d = HOLD;
        MODE_PULSE: begin
          state_d = PULSE;
          done_d  = cnt_tc_next_c;
        end
        MODE_SCAN: begin
          state_d = SCAN;
          done_d  = (Code == CODE_MAX);
        end
        default: ;
      endcase
    end else begin
      err_d = rsvd_c;
      case (state_q)
        PULSE: begin
          if (cnt_tc_c) begin
            state_d = IDLE;
            data_d  = '0;
          end else begin
            done_d = cnt_tc_next_c;
          end
        end
        SCAN: begin
          if (pos_q == CODE_MAX) begin
            state_d = IDLE;
            data_d  = '0;
          end else begin
            pos_d  = pos_q + CODE_W'(1);
            data_d = data_q << 1;
            done_d = (pos_d == CODE_MAX);
          end
        end
        default: ;
      endcase
    end
    ready_d = (state_d == IDLE) || (state_d == HOLD);
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= IDLE;
      data_q  <= '0;
      pos_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      pos_q   <= pos_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign Ready = ready_q;
  assign Data  = data_q;
  assign Done  = done_q;
  assign Err   = err_q;

endmodule
